// File: rtl/deser_pkg.sv
// Shared types and helpers for the 1-to-8 deserializer and its output stage.
package deser_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  sel_t;

    // Slot index of the last bit in a word; accepting here completes the word.
    localparam sel_t SEL_LAST = sel_t'(WORD_W - 1);

    // Returns word with one bit position overwritten by bit_val.
    function automatic word_t insert_bit(input word_t word, input sel_t slot, input logic bit_val);
        word_t result;
        result       = word;
        result[slot] = bit_val;
        return result;
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready holding register. Loads a new entry whenever it is
// empty or its current entry is being taken in the same cycle, so a producer
// can stream into it with no bubble. Shared with the matching serializer.
module deser_out_reg
    import deser_pkg::*;
#(
    parameter int WIDTH = WORD_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    assign in_ready = !out_valid || out_ready;

    // Hold the entry until taken; a transfer with no replacement only drops valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/one_to_eight_deser.sv
// 1-to-8 deserializer: each accepted serial bit is steered into slot sel of an
// assembly register; the completed word is handed to a valid/ready output stage.
// BUFFERED=1 keeps assembling while the output is held; BUFFERED=0 stalls input
// while a word is waiting at the output.
// Optional macro DESER_MSB_FIRST_EN: first bit of a word lands in dout[7]
// (physical slot 7-sel); otherwise the first bit lands in dout[0].
module one_to_eight_deser
    import deser_pkg::*;
#(
    parameter bit BUFFERED = 1'b1
)
(
    input  logic  clk,
    input  logic  rst,
    input  logic  restart,
    input  logic  din,
    input  logic  din_valid,
    output logic  din_ready,
    output sel_t  sel,
    output word_t dout,
    output logic  dout_valid,
    input  logic  dout_ready
);

    word_t asm_word;
    logic  word_pending;
    sel_t  slot;
    word_t word_with_bit;
    logic  accept;
    logic  word_done;
    logic  load_valid;
    logic  load_ready;
    word_t load_data;

    // Input acceptance depends only on registered state plus rst/restart, never on din_valid.
    always_comb begin
        if (BUFFERED) begin
            din_ready = !rst && !restart && !(word_pending && dout_valid);
        end else begin
            din_ready = !rst && !restart && !dout_valid;
        end
    end

    // Map the logical slot to a physical bit, build the updated word and pick what feeds the output stage.
    always_comb begin
`ifdef DESER_MSB_FIRST_EN
        slot = SEL_LAST - sel;
`else
        slot = sel;
`endif
        accept        = din_valid && din_ready;
        word_with_bit = insert_bit(asm_word, slot, din);
        word_done     = accept && (sel == SEL_LAST);
        if (word_pending) begin
            load_valid = !restart;
            load_data  = asm_word;
        end else begin
            load_valid = word_done;
            load_data  = word_with_bit;
        end
    end

    // Assembly state: slot counter, partial word and the parked complete word.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            sel          <= '0;
            asm_word     <= '0;
            word_pending <= 1'b0;
        end else begin
            if (word_pending && load_ready) begin
                word_pending <= 1'b0;
                asm_word     <= '0;
            end
            if (accept) begin
                sel <= sel + sel_t'(1);
                if (word_done) begin
                    if (load_ready) begin
                        asm_word <= '0;
                    end else begin
                        asm_word     <= word_with_bit;
                        word_pending <= 1'b1;
                    end
                end else begin
                    asm_word <= word_with_bit;
                end
            end
        end
    end

    deser_out_reg #(.WIDTH(WORD_W)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_data   (load_data),
        .in_valid  (load_valid),
        .in_ready  (load_ready),
        .out_data  (dout),
        .out_valid (dout_valid),
        .out_ready (dout_ready)
    );

endmodule

// File: doc/one_to_eight_deser.md
Name: one_to_eight_deser

Overview:
- Serial-to-parallel counterpart of the eight_to_one mux.
- Accepts one data bit per handshake and steers it into slot sel of an 8-bit word (a 1-to-8 demux plus holding register).
- Presents each completed word on a valid/ready output.
- Sits at the receive end of a link whose transmit end is an 8:1 mux stepping sel 0..7.

Parameters:
- BUFFERED, 1, 1 = separate assembly and output registers (assembly continues while output is held); 0 = single register, input stalls while output is valid.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- restart  input  1  synchronous frame realign; discards the partial word and sets sel to 0.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  block accepts din this cycle.
- sel  output  3  slot index the next accepted bit will be written to.
- dout  output  8  assembled word.
- dout_valid  output  1  dout holds a complete word.
- dout_ready  input  1  downstream accepts dout this cycle.

Behaviour:
- Reset (rst=1 at clk edge):
  - sel=0; assembly register=0; dout=8'h00; dout_valid=0.
  - din_ready=0 while rst is high; din_ready=1 on the first cycle after rst is released.
  - rst mid-word or with dout_valid=1 drops all data; no partial word is ever emitted.
- Input handshake:
  - A bit is accepted when din_valid && din_ready at the clk edge.
  - Accepted bit is written to slot sel; sel increments mod 8 (7 wraps to 0).
  - din_valid without din_ready: no state change. din is not required to be held stable.
- Completion and latency:
  - Accepting the bit at sel=7 completes the word.
  - Word appears on dout with dout_valid=1 on the next cycle (1-cycle latency from the 8th accept).
  - sel=0 on that same cycle.
- Output handshake:
  - dout/dout_valid hold until dout_valid && dout_ready.
  - On transfer without a new word: dout_valid=0; dout keeps its last value.
- BUFFERED=1:
  - din_ready = !restart && !(word_pending && dout_valid).
  - word_pending means the assembly register is complete but the output register is occupied.
  - Bits 0..7 of the next word are accepted while dout is held; only the bit after a completed pending word stalls.
  - Simultaneous dout transfer and word completion (or a pending word): the new word loads into dout and dout_valid stays 1 with no bubble.
- BUFFERED=0:
  - din_ready = !restart && !dout_valid.
  - Throughput is at most 8 bits per 9 cycles.
- restart:
  - Takes priority over din: din_ready=0 in that cycle and the bit is not accepted.
  - Clears sel and partial bits; clears word_pending.
  - Does not touch dout or dout_valid.
- Bit order: slot k of the word receives the k-th accepted bit.
- No combinational path from din_valid to din_ready. dout_ready may combinationally affect din_ready only in BUFFERED=1 (optional; registered is acceptable).

Optional Feature:
- Macro: DESER_MSB_FIRST_EN.
- Defined: the first accepted bit of a word lands in dout[7], the last in dout[0]. sel still counts 0..7; the physical slot written is 7-sel.
- Undefined: the first bit lands in dout[0] (LSB-first), matching an 8:1 mux driven with sel 0..7.

Decomposition:
- Shared package deser_pkg:
  - localparams WORD_W=8 and SEL_W=3.
  - typedef word_t (logic [WORD_W-1:0]).
  - typedef sel_t (logic [SEL_W-1:0]).
- One natural sub-module: deser_out_reg, a single-entry valid/ready holding register used for the output stage. It is also reusable by the matching serializer.

Test Plan:
- Reset then 8 bits 1,0,1,1,0,0,1,0 at din_valid=1 with dout_ready=1:
  - dout=8'h4D, dout_valid=1 exactly one cycle after the 8th accept, for one cycle.
  - With DESER_MSB_FIRST_EN: dout=8'hB2.
- BUFFERED=1, dout_ready=0, 17 bits offered continuously:
  - First word is held; second word is assembled; din_ready drops only on the 17th bit.
  - Raising dout_ready yields two back-to-back words with no bubble, then din_ready=1.
- BUFFERED=0, dout_ready=0 after a word completes:
  - din_ready=0 until the transfer; the next word starts at sel=0.
- restart after 5 bits, then 8 bits of 8'hA5:
  - Output is 8'hA5 only, with no word from the partial bits.
  - restart asserted together with din_valid: that bit is dropped and sel=0.
- rst asserted with dout_valid=1 and sel=3:
  - Next cycle: dout_valid=0, dout=0, sel=0.
- Random regression, 10k words with random din_valid and dout_ready:
  - Compare against an eight_to_one mux serializer model driven with sel 0..7; zero mismatches, no lost or duplicated words.
